// File: rtl/fluid_board_soc_pio_status_in.sv
// Avalon-MM input PIO for board status lines.
// Every input bit goes through a synchronizer, a debounce filter and an edge
// detector. Detected edges set sticky capture bits. A capture bit drives irq
// only when its mask bit is set.
module fluid_board_soc_pio_status_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_out;
  logic [WIDTH-1:0]                  filt;
  logic [WIDTH-1:0]                  filt_prev_q;
  logic [WIDTH-1:0]                  edge_det;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]                  edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]                  cap_clr;
  logic                              wr_en;

  // Synchronizer shift chain. Stage 0 samples the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign filt = sync_out;
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             filt_q, filt_d;

        // Count consecutive mismatch cycles. Accept the new level only after a full stable run.
        always_comb begin
          cnt_d  = cnt_q;
          filt_d = filt_q;
          if (sync_out[b] == filt_q) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            filt_d = sync_out[b];
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        // Debounce state. A reset drops any partial count.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
          end
        end

        assign filt[b] = filt_q;
      end
    end
  endgenerate

  // Select the edge polarity from the filtered value and its one-cycle-old copy.
  always_comb begin
    edge_det = filt ^ filt_prev_q;
    if (EDGE_TYPE == 0) begin
      edge_det = filt & ~filt_prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~filt & filt_prev_q;
    end
  end

  assign wr_en = chipselect & ~write_n;

  // Mask load and write-1-to-clear for the capture bits. A new edge takes priority over a clear.
  always_comb begin
    irq_mask_d = irq_mask_q;
    cap_clr    = '0;
    if (wr_en && address == ADDR_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_CAP) begin
      cap_clr = writedata[WIDTH-1:0];
    end
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
  end

  // Edge-detect history, mask and sticky capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_prev_q <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
    end else begin
      filt_prev_q <= filt;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
    end
  end

  // Zero-wait-state read mux. Reads have no side effects and ignore chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = filt;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_CAP:  readdata[WIDTH-1:0] = edge_cap_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_fluid_board_soc_pio_status_in.sv
// Directed bench for fluid_board_soc_pio_status_in.
// The main instance uses DEBOUNCE_CYCLES=4 and rising-edge capture.
// Two more instances bypass the debounce filter and capture falling edges or any edge.
module tb_fluid_board_soc_pio_status_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [7:0]  in_alt;
  logic [31:0] readdata, rd_f, rd_a;
  logic        irq, irq_f, irq_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fluid_board_soc_pio_status_in #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  fluid_board_soc_pio_status_in #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)
  ) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_f),
    .in_port(in_alt), .irq(irq_f)
  );

  fluid_board_soc_pio_status_in #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_alt), .irq(irq_a)
  );

  typedef struct {
    string       name;
    logic [7:0]  in_v;
    logic        cs;
    logic        wn;
    logic [1:0]  wa;
    logic [31:0] wd;
    int          n;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic [7:0] in_v, input logic cs,
                     input logic wn, input logic [1:0] wa, input logic [31:0] wd,
                     input int n, input logic [1:0] ra, input logic [31:0] exp_rd,
                     input logic exp_irq);
    vec_t v;
    v.name = name; v.in_v = in_v; v.cs = cs; v.wn = wn; v.wa = wa; v.wd = wd;
    v.n = n; v.ra = ra; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Drive a single-cycle bus write that starts at the next posedge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0; in_alt = '0;

    // name, in_port, cs, write_n, wr addr, wr data, edges, rd addr, exp readdata, exp irq
    add("rst_data",   8'h00, 0, 1, 0, 32'h0,        0, 0, 32'h00, 0);
    add("rst_mask",   8'h00, 0, 1, 0, 32'h0,        0, 1, 32'h00, 0);
    add("rst_rsv",    8'h00, 0, 1, 0, 32'h0,        0, 2, 32'h00, 0);
    add("rst_cap",    8'h00, 0, 1, 0, 32'h0,        0, 3, 32'h00, 0);
    add("b3_data_e5", 8'h08, 0, 1, 0, 32'h0,        5, 0, 32'h00, 0);
    add("b3_data_e6", 8'h08, 0, 1, 0, 32'h0,        1, 0, 32'h08, 0);
    add("b3_cap_e6",  8'h08, 0, 1, 0, 32'h0,        0, 3, 32'h00, 0);
    add("b3_cap_e7",  8'h08, 0, 1, 0, 32'h0,        1, 3, 32'h08, 0);
    add("b3_mask",    8'h08, 1, 0, 1, 32'h08,       1, 1, 32'h08, 1);
    add("b3_clr",     8'h08, 1, 0, 3, 32'h08,       1, 3, 32'h00, 0);
    add("glitch3_a",  8'h09, 0, 1, 0, 32'h0,        3, 0, 32'h08, 0);
    add("glitch3_b",  8'h08, 0, 1, 0, 32'h0,        6, 0, 32'h08, 0);
    add("glitch3_c",  8'h08, 0, 1, 0, 32'h0,        0, 3, 32'h00, 0);
    add("pulse4_a",   8'h09, 0, 1, 0, 32'h0,        4, 0, 32'h08, 0);
    add("pulse4_b",   8'h08, 0, 1, 0, 32'h0,        2, 0, 32'h09, 0);
    add("pulse4_cap", 8'h08, 0, 1, 0, 32'h0,        1, 3, 32'h01, 0);
    add("pulse4_end", 8'h08, 0, 1, 0, 32'h0,        3, 0, 32'h08, 0);
    add("pulse4_clr", 8'h08, 1, 0, 3, 32'h01,       1, 3, 32'h00, 0);
    add("b56_rise",   8'h68, 0, 1, 0, 32'h0,        6, 0, 32'h68, 0);
    add("b56_cap",    8'h68, 0, 1, 0, 32'h0,        1, 3, 32'h60, 0);
    add("b5_fall",    8'h48, 0, 1, 0, 32'h0,        6, 0, 32'h48, 0);
    add("b5_fall_cap",8'h48, 0, 1, 0, 32'h0,        0, 3, 32'h60, 0);
    add("b5_rise2",   8'h68, 0, 1, 0, 32'h0,        6, 0, 32'h68, 0);
    add("set_wins",   8'h68, 1, 0, 3, 32'hFF,       1, 3, 32'h20, 0);
    add("mask_irq",   8'h68, 1, 0, 1, 32'h20,       1, 1, 32'h20, 1);
    add("mask_drop",  8'h68, 1, 0, 1, 32'h00,       1, 3, 32'h20, 0);
    add("wr_data_ro", 8'h68, 1, 0, 0, 32'hFF,       1, 0, 32'h68, 0);
    add("wr_rsv",     8'h68, 1, 0, 2, 32'hFF,       1, 2, 32'h00, 0);
    add("wr_upper",   8'h68, 1, 0, 1, 32'hFFFFFF01, 1, 1, 32'h01, 0);
    add("wr_no_cs",   8'h68, 0, 0, 1, 32'hFF,       1, 1, 32'h01, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      in_port = v.in_v; chipselect = v.cs; write_n = v.wn;
      address = v.wa; writedata = v.wd;
      for (int k = 0; k < v.n; k++) begin
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
      end
      address = v.ra; #1;
      chk(v.name, readdata, v.exp_rd);
      chk({v.name, "_irq"}, {31'b0, irq}, {31'b0, v.exp_irq});
    end

    // Asynchronous reset in the middle of a debounce run
    bus_write(2'd1, 32'hFF);
    address = 2'd1; #1;
    chk("pre_rst_mask", readdata, 32'hFF);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    in_port = 8'hFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a); #1;
      chk("async_rst_rd", readdata, 32'h0);
    end
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1; address = 2'd0; #1;
    chk("post_rst_data_e5", readdata, 32'h00);
    @(posedge clk); #1;
    chk("post_rst_data_e6", readdata, 32'hFF);
    @(posedge clk); #1; address = 2'd3; #1;
    chk("post_rst_cap_e7", readdata, 32'hFF);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    // Unfiltered instances: falling-edge capture and any-edge capture
    in_alt = 8'h80;
    @(posedge clk); #1; address = 2'd0; #1;
    chk("f_data_e1", rd_f, 32'h00);
    chk("a_data_e1", rd_a, 32'h00);
    @(posedge clk); #1;
    chk("f_data_e2", rd_f, 32'h80);
    chk("a_data_e2", rd_a, 32'h80);
    @(posedge clk); #1; address = 2'd3; #1;
    chk("f_rise_cap", rd_f, 32'h00);
    chk("a_rise_cap", rd_a, 32'h80);
    bus_write(2'd3, 32'h80);
    address = 2'd3; #1;
    chk("a_rise_clr", rd_a, 32'h00);
    bus_write(2'd1, 32'h80);
    address = 2'd1; #1;
    chk("f_mask", rd_f, 32'h80);
    chk("f_irq_idle", {31'b0, irq_f}, 32'h0);
    in_alt = 8'h00;
    @(posedge clk);
    @(posedge clk); #1; address = 2'd0; #1;
    chk("f_data_fall", rd_f, 32'h00);
    chk("a_data_fall", rd_a, 32'h00);
    @(posedge clk); #1; address = 2'd3; #1;
    chk("f_fall_cap", rd_f, 32'h80);
    chk("a_fall_cap", rd_a, 32'h80);
    chk("f_fall_irq", {31'b0, irq_f}, 32'h1);
    chk("a_fall_irq", {31'b0, irq_a}, 32'h1);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd2, 32'hFF);
    address = 2'd0; #1;
    chk("f_ro_data", rd_f, 32'h00);
    address = 2'd1; #1;
    chk("a_ro_mask", rd_a, 32'h80);
    address = 2'd3; #1;
    chk("f_ro_cap", rd_f, 32'h80);
    chk("a_ro_cap", rd_a, 32'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
